mulchan_wr_arbiter: RTL and testbench



---
 rtl/mulchan_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/mulchan_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_mulchan_wr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mulchan_arb_pkg.sv
// Shared types and constants for the multi-channel write arbiter.
package mulchan_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } arb_state_e;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned LEN_W  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder: first set request at or after ptr_i.
// With ARB_FIXED_PRIO_EN defined the search always starts at channel 0.
module rr_pick #(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned CH_IDX_W = 2
) (
    input  logic [CH_NUM-1:0]   req_i,
    input  logic [CH_IDX_W-1:0] ptr_i,
    output logic                valid_o,
    output logic [CH_IDX_W-1:0] idx_o
);

    logic [CH_IDX_W-1:0] base;
    logic [CH_IDX_W-1:0] cand;
    logic                found;

`ifdef ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = ptr_i;
`endif

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            cand = CH_IDX_W'((32'(base) + i) % CH_NUM);
            if (!found && req_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mulchan_wr_arbiter.sv
// Round-robin write arbiter feeding a single AXI write master; grant held per burst.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module mulchan_wr_arbiter
    import mulchan_arb_pkg::*;
#(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CH_IDX_W  = 2,
    parameter int unsigned AXI_WIDTH = 64,
    parameter int unsigned ADDR_W    = mulchan_arb_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH_NUM-1:0]             wr_req_i,
    input  logic [CH_NUM*ADDR_W-1:0]      wr_addr_i,
    input  logic [CH_NUM*LEN_W-1:0]       wr_len_i,
    input  logic [CH_NUM*AXI_WIDTH-1:0]   wr_data_i,
    output logic [CH_NUM-1:0]             wr_grant_o,
    output logic                          axi_wr_start_o,
    output logic [ADDR_W-1:0]             axi_wr_addr_o,
    output logic [LEN_W-1:0]              axi_wr_len_o,
    output logic [AXI_WIDTH-1:0]          axi_wr_data_o,
    input  logic                          axi_wr_done_i
);

    arb_state_e            state_q, state_d;
    logic [CH_NUM-1:0]     grant_q, grant_d;
    logic [CH_IDX_W-1:0]   idx_q, idx_d;
    logic                  start_q, start_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CH_IDX_W-1:0]   ptr;
    logic                  pick_valid;
    logic [CH_IDX_W-1:0]   pick_idx;

    rr_pick #(
        .CH_NUM   (CH_NUM),
        .CH_IDX_W (CH_IDX_W)
    ) u_rr_pick (
        .req_i   (wr_req_i),
        .ptr_i   (ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = CH_NUM'(1) << pick_idx;
                    idx_d   = pick_idx;
                    addr_d  = wr_addr_i[pick_idx*ADDR_W +: ADDR_W];
                    len_d   = wr_len_i[pick_idx*LEN_W +: LEN_W];
                    start_d = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                // Grant stays high during the done cycle so the channel sees grant&&done.
                if (axi_wr_done_i) begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [CH_IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StWait && axi_wr_done_i) begin
            ptr_d = (idx_q == CH_IDX_W'(CH_NUM - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    assign wr_grant_o     = grant_q;
    assign axi_wr_start_o = start_q;
    assign axi_wr_addr_o  = addr_q;
    assign axi_wr_len_o   = len_q;
    assign axi_wr_data_o  = (|grant_q) ? wr_data_i[idx_q*AXI_WIDTH +: AXI_WIDTH] : '0;

endmodule

// File: tb/tb_mulchan_wr_arbiter.sv
// Scoreboard bench for mulchan_wr_arbiter: expected bursts are queued by the driver
// and checked by a monitor on every axi_wr_start pulse.
module tb_mulchan_wr_arbiter;

    localparam int unsigned CH   = 4;
    localparam int unsigned AW   = 30;
    localparam int unsigned DW   = 64;

    typedef struct packed {
        logic [1:0]    ch;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     wr_req = '0;
    logic [CH*AW-1:0]  wr_addr = '0;
    logic [CH*8-1:0]   wr_len = '0;
    logic [CH*DW-1:0]  wr_data = '0;
    logic [CH-1:0]     wr_grant;
    logic              axi_wr_start;
    logic [AW-1:0]     axi_wr_addr;
    logic [7:0]        axi_wr_len;
    logic [DW-1:0]     axi_wr_data;
    logic              axi_wr_done = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   onehot_err = 0;
    int   dbl_start_err = 0;
    logic prev_start = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mulchan_wr_arbiter #(
        .CH_NUM    (CH),
        .CH_IDX_W  (2),
        .AXI_WIDTH (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req_i       (wr_req),
        .wr_addr_i      (wr_addr),
        .wr_len_i       (wr_len),
        .wr_data_i      (wr_data),
        .wr_grant_o     (wr_grant),
        .axi_wr_start_o (axi_wr_start),
        .axi_wr_addr_o  (axi_wr_addr),
        .axi_wr_len_o   (axi_wr_len),
        .axi_wr_data_o  (axi_wr_data),
        .axi_wr_done_i  (axi_wr_done)
    );

    function automatic logic [DW-1:0] data_of(input int ch);
        return 64'hA5A5_0000_0000_0000 | 64'(ch + 1) * 64'h1111;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int ch);
        return AW'((ch + 1) * 'h100);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.ch   = 2'(ch);
        e.addr = addr_of(ch);
        e.len  = 8'(15 + ch);
        sb.push_back(e);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!axi_wr_start && n < 50) begin
            cyc(1);
            n++;
        end
        check("start_seen", 64'(axi_wr_start), 64'd1);
    endtask

    task automatic pulse_done();
        axi_wr_done = 1'b1;
        cyc(1);
        axi_wr_done = 1'b0;
    endtask

    // Monitor: compare each burst start against the scoreboard head.
    always @(negedge clk) begin
        if (!$onehot0(wr_grant)) onehot_err++;
        if (prev_start && axi_wr_start) dbl_start_err++;
        prev_start = axi_wr_start;
        if (rst_n && axi_wr_start) begin
            if (sb.size() == 0) begin
                check("sb_empty_on_start", 64'(wr_grant), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_grant", 64'(wr_grant), 64'(4'b0001 << e.ch));
                check("mon_addr", 64'(axi_wr_addr), 64'(e.addr));
                check("mon_len", 64'(axi_wr_len), 64'(e.len));
                check("mon_data", axi_wr_data, data_of(int'(e.ch)));
            end
        end
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            wr_addr[i*AW +: AW] = addr_of(i);
            wr_len[i*8 +: 8]    = 8'(15 + i);
            wr_data[i*DW +: DW] = data_of(i);
        end
        #12;
        check("rst_grant", 64'(wr_grant), 64'd0);
        check("rst_start", 64'(axi_wr_start), 64'd0);
        check("rst_addr", 64'(axi_wr_addr), 64'd0);
        check("rst_len", 64'(axi_wr_len), 64'd0);
        check("rst_data", axi_wr_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);

        // Single request on channel 0.
        wr_req = 4'b0001;
        push(0);
        cyc(1);
        check("single_grant", 64'(wr_grant), 64'b0001);
        check("single_start", 64'(axi_wr_start), 64'd1);
        wr_req = 4'b0000;
        cyc(1);
        check("single_start_drop", 64'(axi_wr_start), 64'd0);
        check("single_hold", 64'(wr_grant), 64'b0001);
        cyc(19);
        check("single_hold_late", 64'(wr_grant), 64'b0001);
        pulse_done();
        check("single_release", 64'(wr_grant), 64'd0);

        // Done while idle must be ignored.
        pulse_done();
        check("idle_done_grant", 64'(wr_grant), 64'd0);
        check("idle_done_start", 64'(axi_wr_start), 64'd0);

        // Address change during the burst must not leak through.
        wr_req = 4'b0010;
        push(1);
        cyc(1);
        wr_req = 4'b0000;
        cyc(2);
        wr_addr[1*AW +: AW] = AW'('h300);
        cyc(1);
        check("latched_addr", 64'(axi_wr_addr), 64'h200);
        check("wait_data_mux", axi_wr_data, data_of(1));
        wr_addr[1*AW +: AW] = addr_of(1);
        pulse_done();
        check("ch1_release", 64'(wr_grant), 64'd0);
        check("idle_data_zero", axi_wr_data, 64'd0);

        // Reset mid-burst drops the grant asynchronously.
        wr_req = 4'b1000;
        push(3);
        cyc(1);
        wr_req = 4'b0000;
        cyc(3);
        check("pre_rst_grant", 64'(wr_grant), 64'b1000);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 64'(wr_grant), 64'd0);
        check("async_rst_start", 64'(axi_wr_start), 64'd0);
        wr_req = 4'b1111;
        cyc(1);
        rst_n = 1'b1;

        // All channels requesting: 0,1,2,3,0 round-robin, or always 0 in fixed priority.
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            push(0);
`else
            push(k % 4);
`endif
        end
        for (int k = 0; k < 5; k++) begin
            wait_start();
            if (k == 4) wr_req = 4'b0000;
            cyc(3);
            pulse_done();
            check("rr_release", 64'(wr_grant), 64'd0);
            if (k < 4) begin
                cyc(1);
                check("rr_gap_start", 64'(axi_wr_start), 64'd1);
            end
        end
        cyc(3);
        check("final_grant", 64'(wr_grant), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("onehot0_grant", 64'(onehot_err), 64'd0);
        check("start_one_cycle", 64'(dbl_start_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
